// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt bus slave between NUM_MASTERS masters.
// The owner's request is registered onto the slave side; completion or timeout returns a one-cycle gnt.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         m_req,
    input  logic [NUM_MASTERS-1:0]         m_wr_en,
    input  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]  m_wdata,
    output logic [NUM_MASTERS-1:0]         m_gnt,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           m_err,
    output logic                           s_req,
    output logic                           s_wr_en,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_gnt,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] owner
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]         r_owner, w_owner_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [NUM_MASTERS-1:0]   r_m_gnt, w_m_gnt_nxt;
    logic [DATA_W-1:0]        r_m_rdata, w_m_rdata_nxt;
    logic                     r_m_err, w_m_err_nxt;
    logic                     r_s_req, w_s_req_nxt;
    logic                     r_s_wr_en, w_s_wr_en_nxt;
    logic [ADDR_W-1:0]        r_s_addr, w_s_addr_nxt;
    logic [DATA_W-1:0]        r_s_wdata, w_s_wdata_nxt;
    logic                     r_busy;
    logic [IDX_W-1:0]         w_winner;
    logic                     w_found;
    logic                     w_timeout;

    // Winner is the first requester at or after the registered pointer, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_found && m_req[(int'(r_ptr) + k) % NUM_MASTERS]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'((int'(r_ptr) + k) % NUM_MASTERS);
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = ACCESS;
            ACCESS:  if (s_gnt || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = RELEASE;
            RELEASE: if (!m_req[r_owner]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_m_gnt_nxt   = '0;
        w_m_rdata_nxt = r_m_rdata;
        w_m_err_nxt   = 1'b0;
        w_s_req_nxt   = r_s_req;
        w_s_wr_en_nxt = r_s_wr_en;
        w_s_addr_nxt  = r_s_addr;
        w_s_wdata_nxt = r_s_wdata;
        case (r_state)
            IDLE: if (w_found) begin
                w_owner_nxt   = w_winner;
                w_ptr_nxt     = (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + IDX_W'(1);
                w_cnt_nxt     = '0;
                w_s_req_nxt   = 1'b1;
                w_s_wr_en_nxt = m_wr_en[w_winner];
                w_s_addr_nxt  = m_addr[w_winner*ADDR_W +: ADDR_W];
                w_s_wdata_nxt = m_wdata[w_winner*DATA_W +: DATA_W];
            end
            ACCESS: begin
                // A slave grant wins over an expiring timeout in the same cycle.
                if (s_gnt) begin
                    w_m_gnt_nxt   = NUM_MASTERS'(1) << r_owner;
                    w_m_rdata_nxt = s_rdata;
                    w_s_req_nxt   = 1'b0;
                    w_s_wr_en_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_m_gnt_nxt   = NUM_MASTERS'(1) << r_owner;
                    w_m_err_nxt   = 1'b1;
                    w_m_rdata_nxt = '0;
                    w_s_req_nxt   = 1'b0;
                    w_s_wr_en_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_m_gnt   <= '0;
            r_m_rdata <= '0;
            r_m_err   <= 1'b0;
            r_s_req   <= 1'b0;
            r_s_wr_en <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_m_gnt   <= w_m_gnt_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_m_err   <= w_m_err_nxt;
            r_s_req   <= w_s_req_nxt;
            r_s_wr_en <= w_s_wr_en_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_wdata <= w_s_wdata_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign m_gnt   = r_m_gnt;
    assign m_rdata = r_m_rdata;
    assign m_err   = r_m_err;
    assign s_req   = r_s_req;
    assign s_wr_en = r_s_wr_en;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign busy    = r_busy;
    assign owner   = r_owner;

endmodule
